pattern_sequencer: RTL and testbench

Controller that shares the 8-entry × 8-bit pattern memory and its serial bit output between two requesters. It arbitrates requests, drives the memory address, captures the addressed word and shifts it out one bit per accepted transfer, index 0 first, under a valid/ready handshake. It replaces the free-running counter/decoder sequencing in front of the pattern memory and serializer path.

---
 rtl/pattern_sequencer.sv | 152 +++++++++++++++
 tb/tb_pattern_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// ============================================================================
// Module   : pattern_sequencer
// Brief    : Two-requester arbiter + pattern-memory fetch + handshaked serializer.
//            Define PATSEQ_ROUND_ROBIN_EN for round-robin arbitration (default: REQ0 priority).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pattern_sequencer (
  input  logic       CLOCK,
  input  logic       CLEAR_N,
  input  logic       REQ0,
  input  logic [2:0] ADDR0,
  input  logic       REQ1,
  input  logic [2:0] ADDR1,
  output logic       GNT0,
  output logic       GNT1,
  output logic [2:0] MEM_ADDR,
  input  logic [0:7] MEM_DATA,
  output logic       SER_OUT,
  output logic       SER_VALID,
  input  logic       SER_READY,
  output logic [2:0] BIT_IDX,
  output logic       BUSY,
  output logic       DONE
);

`ifdef PATSEQ_ROUND_ROBIN_EN
  localparam logic c_ROUND_ROBIN = 1'b1;
`else
  localparam logic c_ROUND_ROBIN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     r_state, w_state;
  logic       r_gnt0, w_gnt0;
  logic       r_gnt1, w_gnt1;
  logic [2:0] r_mem_addr, w_mem_addr;
  logic [0:7] r_shreg, w_shreg;
  logic [2:0] r_bit_idx, w_bit_idx;
  logic       r_valid, w_valid;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_last, w_last;
  logic       w_req_any;
  logic       w_pick1;
  logic       w_grant;

  assign w_req_any = REQ0 | REQ1;
  // Requester 1 wins alone, or on a tie when round-robin says it is its turn.
  assign w_pick1   = REQ1 & (~REQ0 | (c_ROUND_ROBIN & ~r_last));

  always_ff @(posedge CLOCK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      r_state    <= ST_IDLE;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_mem_addr <= 3'd0;
      r_shreg    <= 8'd0;
      r_bit_idx  <= 3'd0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_last     <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_gnt0     <= w_gnt0;
      r_gnt1     <= w_gnt1;
      r_mem_addr <= w_mem_addr;
      r_shreg    <= w_shreg;
      r_bit_idx  <= w_bit_idx;
      r_valid    <= w_valid;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_last     <= w_last;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_mem_addr = r_mem_addr;
    w_shreg    = r_shreg;
    w_bit_idx  = r_bit_idx;
    w_valid    = r_valid;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_last     = r_last;
    w_grant    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_grant = w_req_any;
      end
      ST_FETCH: begin
        w_shreg   = MEM_DATA;
        w_bit_idx = 3'd0;
        w_valid   = 1'b1;
        w_state   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (SER_READY) begin
          if (r_bit_idx == 3'd7) begin
            w_valid   = 1'b0;
            w_done    = 1'b1;
            w_bit_idx = 3'd0;
            w_state   = ST_DONE;
          end else begin
            w_bit_idx = r_bit_idx + 3'd1;
          end
        end
      end
      ST_DONE: begin
        // The closing edge of DONE may already grant, giving a 10-cycle pattern period.
        w_busy  = 1'b0;
        w_state = ST_IDLE;
        w_grant = w_req_any;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    if (w_grant) begin
      w_gnt0     = ~w_pick1;
      w_gnt1     = w_pick1;
      w_mem_addr = w_pick1 ? ADDR1 : ADDR0;
      w_busy     = 1'b1;
      w_last     = w_pick1;
      w_state    = ST_FETCH;
    end
  end

  assign GNT0      = r_gnt0;
  assign GNT1      = r_gnt1;
  assign MEM_ADDR  = r_mem_addr;
  assign SER_OUT   = r_valid & r_shreg[r_bit_idx];
  assign SER_VALID = r_valid;
  assign BIT_IDX   = r_bit_idx;
  assign BUSY      = r_busy;
  assign DONE      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
// ============================================================================
// Module   : tb_pattern_sequencer
// Brief    : Scoreboard bench for pattern_sequencer with a behavioural pattern memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_sequencer;

  logic       CLOCK = 1'b0;
  logic       CLEAR_N = 1'b0;
  logic       REQ0 = 1'b0;
  logic       REQ1 = 1'b0;
  logic [2:0] ADDR0 = 3'd0;
  logic [2:0] ADDR1 = 3'd0;
  logic       SER_READY = 1'b0;
  logic       GNT0, GNT1, SER_OUT, SER_VALID, BUSY, DONE;
  logic [2:0] MEM_ADDR, BIT_IDX;
  logic [0:7] MEM_DATA;

  pattern_sequencer dut (
    .CLOCK     (CLOCK),
    .CLEAR_N   (CLEAR_N),
    .REQ0      (REQ0),
    .ADDR0     (ADDR0),
    .REQ1      (REQ1),
    .ADDR1     (ADDR1),
    .GNT0      (GNT0),
    .GNT1      (GNT1),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_DATA  (MEM_DATA),
    .SER_OUT   (SER_OUT),
    .SER_VALID (SER_VALID),
    .SER_READY (SER_READY),
    .BIT_IDX   (BIT_IDX),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // word[a] = 2^(a+1)-1, index 0 is the MSB
  function automatic logic [0:7] model_word(input logic [2:0] a);
    logic [8:0] t;
    t = (9'd1 << ({1'b0, a} + 4'd1)) - 9'd1;
    return t[7:0];
  endfunction

  assign MEM_DATA = model_word(MEM_ADDR);

  typedef struct packed {
    logic       who;
    logic [2:0] addr;
  } gnt_t;

  gnt_t       exp_q[$];
  logic [0:7] word_q[$];
  gnt_t       mon_e;
  logic [0:7] obs_word;
  logic [2:0] bit_cnt = 3'd0;
  int         cyc = 0;
  int         gnt0_cnt = 0;
  int         gnt1_cnt = 0;
  int         done_cnt = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) begin
    if (!CLEAR_N) begin
      bit_cnt = 3'd0;
      word_q.delete();
    end else begin
      check("exclusive_pulses", {30'd0, GNT0 & GNT1, DONE & SER_VALID}, 32'd0);
      if (GNT0 | GNT1) begin
        if (GNT0) gnt0_cnt++;
        if (GNT1) gnt1_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_gnt", {30'd0, GNT1, GNT0}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("gnt_who", {30'd0, GNT1, GNT0}, mon_e.who ? 32'd2 : 32'd1);
          check("mem_addr", {29'd0, MEM_ADDR}, {29'd0, mon_e.addr});
          word_q.push_back(model_word(mon_e.addr));
          bit_cnt = 3'd0;
        end
      end
      if (SER_VALID && SER_READY) begin
        check("bit_idx", {29'd0, BIT_IDX}, {29'd0, bit_cnt});
        obs_word[bit_cnt] = SER_OUT;
        if (bit_cnt == 3'd7) begin
          if (word_q.size() == 0) check("unexpected_stream", 32'd1, 32'd0);
          else check("stream", {24'd0, obs_word}, {24'd0, word_q.pop_front()});
          bit_cnt = 3'd0;
        end else begin
          bit_cnt = bit_cnt + 3'd1;
        end
      end
      if (DONE) done_cnt++;
    end
  end

  // sel: 0 GNT0, 1 GNT1, 2 DONE, 3 !BUSY, 4 any GNT, 5 SER_VALID at BIT_IDX==idx
  task automatic wait_for(input int sel, input string tag, input logic [2:0] idx, output int at);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(posedge CLOCK);
      #1;
      case (sel)
        0:       hit = GNT0;
        1:       hit = GNT1;
        2:       hit = DONE;
        3:       hit = !BUSY;
        4:       hit = GNT0 | GNT1;
        5:       hit = SER_VALID && (BIT_IDX == idx);
        default: hit = 1'b1;
      endcase
    end
    at = cyc;
    if (!hit) check({"timeout_", tag}, 32'd0, 32'd1);
  endtask

  task automatic push_gnt(input logic who, input logic [2:0] a);
    exp_q.push_back(gnt_t'{who, a});
  endtask

  task automatic pulse_reset();
    CLEAR_N = 1'b0;
    @(posedge CLOCK);
    #1;
    CLEAR_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, d, g0, g1, dn;
    logic [0:7] w;

    // reset values
    repeat (3) @(posedge CLOCK);
    #1;
    check("reset_outs", {20'd0, GNT0, GNT1, MEM_ADDR, SER_OUT, SER_VALID, BIT_IDX, BUSY, DONE}, 32'd0);
    CLEAR_N   = 1'b1;
    SER_READY = 1'b1;

    // single transfer, addr 2
    g0 = gnt0_cnt;
    push_gnt(1'b0, 3'd2);
    REQ0 = 1'b1; ADDR0 = 3'd2;
    wait_for(0, "a_gnt", 3'd0, k);
    REQ0 = 1'b0;
    check("a_mem_addr", {29'd0, MEM_ADDR}, 32'd2);
    check("a_busy", {31'd0, BUSY}, 32'd1);
    wait_for(2, "a_done", 3'd0, d);
    check("a_done_lat", d - k, 32'd9);
    wait_for(3, "a_idle", 3'd0, t);
    check("a_idle_lat", t - k, 32'd10);
    check("a_gnt0_once", gnt0_cnt - g0, 32'd1);

    // back-pressure at BIT_IDX 4 for 3 cycles
    w = model_word(3'd2);
    push_gnt(1'b0, 3'd2);
    REQ0 = 1'b1; ADDR0 = 3'd2;
    wait_for(0, "b_gnt", 3'd0, k);
    REQ0 = 1'b0;
    wait_for(5, "b_idx4", 3'd4, t);
    check("b_idx4_at", t - k, 32'd5);
    SER_READY = 1'b0;
    repeat (3) begin
      @(posedge CLOCK);
      #1;
      check("b_hold_idx", {29'd0, BIT_IDX}, 32'd4);
      check("b_hold_valid", {31'd0, SER_VALID}, 32'd1);
      check("b_hold_ser", {31'd0, SER_OUT}, {31'd0, w[4]});
    end
    SER_READY = 1'b1;
    wait_for(2, "b_done", 3'd0, d);
    check("b_done_lat", d - k, 32'd12);
    wait_for(3, "b_idle", 3'd0, t);

    // both requesters held, starting from LAST=1
    pulse_reset();
    g1 = gnt1_cnt;
`ifdef PATSEQ_ROUND_ROBIN_EN
    push_gnt(1'b0, 3'd0); push_gnt(1'b1, 3'd7); push_gnt(1'b0, 3'd0);
`else
    push_gnt(1'b0, 3'd0); push_gnt(1'b0, 3'd0); push_gnt(1'b0, 3'd0);
`endif
    REQ0 = 1'b1; ADDR0 = 3'd0;
    REQ1 = 1'b1; ADDR1 = 3'd7;
    wait_for(4, "c_g1", 3'd0, k);
    wait_for(4, "c_g2", 3'd0, t);
    check("c_gap1", t - k, 32'd10);
    wait_for(4, "c_g3", 3'd0, d);
    check("c_gap2", d - t, 32'd10);
    REQ0 = 1'b0; REQ1 = 1'b0;
    wait_for(3, "c_idle", 3'd0, t);
`ifdef PATSEQ_ROUND_ROBIN_EN
    check("c_gnt1_cnt", gnt1_cnt - g1, 32'd1);
`else
    check("c_gnt1_cnt", gnt1_cnt - g1, 32'd0);
`endif

    // REQ1 raised while busy and withdrawn before DONE
    push_gnt(1'b0, 3'd3);
    REQ0 = 1'b1; ADDR0 = 3'd3;
    wait_for(0, "d_gnt", 3'd0, k);
    REQ0 = 1'b0;
    g1 = gnt1_cnt;
    REQ1 = 1'b1; ADDR1 = 3'd4;
    wait_for(5, "d_idx5", 3'd5, t);
    REQ1 = 1'b0;
    wait_for(2, "d_done", 3'd0, d);
    wait_for(3, "d_idle", 3'd0, t);
    repeat (3) @(posedge CLOCK);
    #1;
    check("d_no_gnt1", gnt1_cnt - g1, 32'd0);

    // asynchronous clear mid-shift
    push_gnt(1'b0, 3'd4);
    REQ0 = 1'b1; ADDR0 = 3'd4;
    wait_for(0, "e_gnt", 3'd0, k);
    REQ0 = 1'b0;
    wait_for(5, "e_idx3", 3'd3, t);
    dn = done_cnt;
    CLEAR_N = 1'b0;
    #1;
    check("e_reset_outs", {20'd0, GNT0, GNT1, MEM_ADDR, SER_OUT, SER_VALID, BIT_IDX, BUSY, DONE}, 32'd0);
    @(posedge CLOCK);
    #1;
    CLEAR_N = 1'b1;
    repeat (12) @(posedge CLOCK);
    #1;
    check("e_no_done", done_cnt - dn, 32'd0);
    check("e_not_busy", {31'd0, BUSY}, 32'd0);
    push_gnt(1'b1, 3'd5);
    REQ1 = 1'b1; ADDR1 = 3'd5;
    wait_for(1, "e_gnt1", 3'd0, k);
    REQ1 = 1'b0;
    wait_for(2, "e_done", 3'd0, d);
    check("e_done_lat", d - k, 32'd9);
    wait_for(3, "e_idle", 3'd0, t);

    // back-to-back requests from requester 0
    push_gnt(1'b0, 3'd1);
    REQ0 = 1'b1; ADDR0 = 3'd1;
    wait_for(0, "f_g1", 3'd0, k);
    ADDR0 = 3'd6;
    push_gnt(1'b0, 3'd6);
    wait_for(0, "f_g2", 3'd0, t);
    REQ0 = 1'b0;
    check("f_gap", t - k, 32'd10);
    wait_for(3, "f_idle", 3'd0, d);
    repeat (2) @(posedge CLOCK);
    #1;
    check("sb_empty", exp_q.size() + word_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
